cell_fetch: RTL and testbench

Reads cells out of the cell cache and streams each one to the downstream consumer as fixed-width beats over a valid/ready handshake. It is the read-side partner of the cache writer. It tracks how many written cells remain unread, so it never reads a cell before it has been written. It walks cache addresses 0..CELL_NUM-1 once per frame.

---
 rtl/cell_fetch_pkg.sv | 7 +
 rtl/cell_serializer.sv | 34 +++
 rtl/cell_fetch.sv | 77 +++++++
 tb/tb_cell_fetch.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cell_fetch_pkg.sv
// cell_fetch_pkg: shared cell-cache geometry defaults and fetch FSM encodings
package cell_fetch_pkg;
  localparam int CELL_WIDTH_DEF = 768;
  localparam int CELL_NUM_DEF = 1200;
  localparam int BEAT_WIDTH_DEF = 64;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SEND} state_e;
endpackage

// File: rtl/cell_serializer.sv
// cell_serializer: holds one cell and shifts it out LSB-first as BEAT_WIDTH beats
module cell_serializer #(
  parameter int CELL_WIDTH = 768,
  parameter int BEAT_WIDTH = 64,
  localparam int BEAT_NUM = CELL_WIDTH / BEAT_WIDTH,
  localparam int BCW = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic                  active_i,
  input  logic [CELL_WIDTH-1:0] cell_i,
  output logic [BEAT_WIDTH-1:0] beat_data_o,
  output logic                  beat_last_o
);
  logic [CELL_WIDTH-1:0] cell_buf_q;
  logic [BCW-1:0] beat_cnt_q;
  // capture a fresh cell, or drop the beat just accepted downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cell_buf_q <= '0;
      beat_cnt_q <= '0;
    end else if (load_i) begin
      cell_buf_q <= cell_i;
      beat_cnt_q <= '0;
    end else if (shift_i) begin
      cell_buf_q <= cell_buf_q >> BEAT_WIDTH;
      beat_cnt_q <= beat_cnt_q + BCW'(1);
    end
  end
  assign beat_data_o = cell_buf_q[BEAT_WIDTH-1:0];
  assign beat_last_o = active_i && beat_cnt_q == BCW'(BEAT_NUM - 1);
endmodule

// File: rtl/cell_fetch.sv
// cell_fetch: streams written cache cells out as beats, one frame of CELL_NUM cells per start
module cell_fetch
  import cell_fetch_pkg::*;
#(
  parameter int CELL_WIDTH = CELL_WIDTH_DEF,
  parameter int CELL_NUM = CELL_NUM_DEF,
  parameter int BEAT_WIDTH = BEAT_WIDTH_DEF,
  localparam int CELL_ADDR_W = $clog2(CELL_NUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start_i,
  input  logic                   cell_wr_en_i,
  output logic [CELL_ADDR_W-1:0] cell_rd_addr_o,
  input  logic [CELL_WIDTH-1:0]  cell_rd_data_i,
  output logic [BEAT_WIDTH-1:0]  beat_data_o,
  output logic                   beat_valid_o,
  input  logic                   beat_ready_i,
  output logic                   beat_last_o,
  output logic                   frame_last_o,
  output logic                   frame_done_o,
  output logic                   busy_o
);
  localparam int CRW = CELL_ADDR_W + 1;
  state_e state_q;
  logic [CRW-1:0] credit_q, credit_d;
  logic [CELL_ADDR_W-1:0] rd_addr_q;
  logic done_q, load, hs, last_cell;
  assign load = state_q == ST_WAIT && credit_q != '0;
  assign hs = beat_valid_o && beat_ready_i;
  assign last_cell = rd_addr_q == CELL_ADDR_W'(CELL_NUM - 1);
  assign beat_valid_o = state_q == ST_SEND;
  assign frame_last_o = beat_last_o && last_cell;
  assign frame_done_o = done_q;
  assign busy_o = state_q != ST_IDLE;
  assign cell_rd_addr_o = rd_addr_q;
  // count written-but-unread cells; a write and a load together cancel out
  always_comb begin
    credit_d = (cell_wr_en_i && !load) ? (credit_q == CRW'(CELL_NUM) ? credit_q : credit_q + CRW'(1))
             : (!cell_wr_en_i && load) ? credit_q - CRW'(1) : credit_q;
  end
  // frame sequencing: wait for a written cell, send its beats, advance the address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      credit_q <= '0;
      rd_addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      credit_q <= credit_d;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (frame_start_i) begin
          state_q <= ST_WAIT;
          rd_addr_q <= '0;
        end
        ST_WAIT: if (load) state_q <= ST_SEND;
        ST_SEND: if (hs && beat_last_o) begin
          rd_addr_q <= last_cell ? '0 : rd_addr_q + CELL_ADDR_W'(1);
          state_q <= last_cell ? ST_IDLE : ST_WAIT;
          done_q <= last_cell;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  cell_serializer #(.CELL_WIDTH(CELL_WIDTH), .BEAT_WIDTH(BEAT_WIDTH)) u_ser (
    .clk(clk),
    .rst(rst),
    .load_i(load),
    .shift_i(hs),
    .active_i(beat_valid_o),
    .cell_i(cell_rd_data_i),
    .beat_data_o(beat_data_o),
    .beat_last_o(beat_last_o)
  );
endmodule

// File: tb/tb_cell_fetch.sv
// tb_cell_fetch: directed checks on a full-size and a 4-cell/2-beat cell_fetch
module tb_cell_fetch;
  logic clk = 0, rst = 1;
  int tests = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic b_start = 0, b_wr = 0, b_ready = 0;
  logic [10:0] b_addr;
  logic [767:0] b_rd;
  logic [63:0] b_data;
  logic b_valid, b_last, b_flast, b_done, b_busy;

  logic s_start = 0, s_wr = 0, s_ready = 0;
  logic [1:0] s_addr;
  logic [127:0] s_rd;
  logic [63:0] s_data;
  logic s_valid, s_last, s_flast, s_done, s_busy;

  function automatic logic [63:0] big_word(input logic [10:0] a, input int k);
    return {16'hC0DE, 5'd0, a, 24'd0, 8'(k)};
  endfunction
  function automatic logic [767:0] big_cell(input logic [10:0] a);
    logic [767:0] c;
    for (int k = 0; k < 12; k++) c[k*64 +: 64] = big_word(a, k);
    return c;
  endfunction
  function automatic logic [63:0] small_word(input logic [1:0] a, input int k);
    return {8'hB0, 6'd0, a, 40'd0, 8'(k)};
  endfunction

  assign b_rd = big_cell(b_addr);
  assign s_rd = {small_word(s_addr, 1), small_word(s_addr, 0)};

  cell_fetch u_big (
    .clk(clk), .rst(rst), .frame_start_i(b_start), .cell_wr_en_i(b_wr),
    .cell_rd_addr_o(b_addr), .cell_rd_data_i(b_rd), .beat_data_o(b_data),
    .beat_valid_o(b_valid), .beat_ready_i(b_ready), .beat_last_o(b_last),
    .frame_last_o(b_flast), .frame_done_o(b_done), .busy_o(b_busy)
  );
  cell_fetch #(.CELL_WIDTH(128), .CELL_NUM(4), .BEAT_WIDTH(64)) u_small (
    .clk(clk), .rst(rst), .frame_start_i(s_start), .cell_wr_en_i(s_wr),
    .cell_rd_addr_o(s_addr), .cell_rd_data_i(s_rd), .beat_data_o(s_data),
    .beat_valid_o(s_valid), .beat_ready_i(s_ready), .beat_last_o(s_last),
    .frame_last_o(s_flast), .frame_done_o(s_done), .busy_o(s_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic big_idle_chk(input string tag);
    chk({tag, " valid"}, b_valid, 0);
    chk({tag, " data"}, b_data, 0);
    chk({tag, " last"}, b_last, 0);
    chk({tag, " flast"}, b_flast, 0);
    chk({tag, " done"}, b_done, 0);
    chk({tag, " busy"}, b_busy, 0);
    chk({tag, " addr"}, 64'(b_addr), 0);
  endtask

  // wait (bounded) for a small-DUT beat, check it, and hand it off on the next edge
  task automatic get_beat(input int c, input int b);
    for (int w = 0; w < 20 && !s_valid; w++) tick();
    chk($sformatf("s_valid c%0d b%0d", c, b), s_valid, 1);
    chk($sformatf("s_data c%0d b%0d", c, b), s_data, small_word(2'(c), b));
    chk($sformatf("s_last c%0d b%0d", c, b), s_last, b == 1);
    chk($sformatf("s_flast c%0d b%0d", c, b), s_flast, c == 3 && b == 1);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t0;
    #1;
    big_idle_chk("reset");
    chk("s reset busy", s_busy, 0);
    chk("s reset valid", s_valid, 0);
    tick(); tick();
    rst = 0;
    tick();
    // single cell on the full-size block
    b_wr = 1; tick(); b_wr = 0;
    b_start = 1; tick(); b_start = 0;
    chk("b busy after start", b_busy, 1);
    chk("b wait valid", b_valid, 0);
    b_ready = 1;
    tick();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("b valid beat%0d", i), b_valid, 1);
      chk($sformatf("b data beat%0d", i), b_data, big_word(0, i));
      chk($sformatf("b last beat%0d", i), b_last, i == 11);
      tick();
    end
    chk("b addr after cell0", 64'(b_addr), 1);
    chk("b valid after cell0", b_valid, 0);
    // starvation: no credit, so nothing may be sent
    k = 0;
    for (int i = 0; i < 20; i++) begin
      k += b_valid;
      tick();
    end
    chk("b starved valid count", 64'(k), 0);
    b_wr = 1; tick(); b_wr = 0;
    chk("b valid t+1", b_valid, 0);
    tick();
    chk("b valid t+2", b_valid, 1);
    // backpressure with ready pattern 1,0,0,1
    k = 0;
    for (int i = 0; k < 12 && i < 100; i++) begin
      b_ready = (i % 4 == 0) || (i % 4 == 3);
      chk($sformatf("bp valid i%0d", i), b_valid, 1);
      chk($sformatf("bp data i%0d", i), b_data, big_word(1, k));
      chk($sformatf("bp last i%0d", i), b_last, k == 11);
      tick();
      if (b_ready) k++;
    end
    chk("bp beats", 64'(k), 12);
    chk("bp addr", 64'(b_addr), 2);
    chk("bp valid after", b_valid, 0);
    // async reset mid-SEND with a pending credit that must be discarded
    b_ready = 0;
    b_wr = 1; tick(); b_wr = 0;
    tick();
    chk("pre-rst valid", b_valid, 1);
    b_wr = 1; tick(); b_wr = 0;
    chk("pre-rst held data", b_data, big_word(2, 0));
    #2 rst = 1;
    #1;
    big_idle_chk("async rst");
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post-rst busy", b_busy, 0);
    end
    b_start = 1; tick(); b_start = 0;
    chk("post-rst busy after start", b_busy, 1);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      k += b_valid;
    end
    chk("post-rst no credit", 64'(k), 0);
    // full frame on the 4-cell block
    s_wr = 1; tick(); tick(); tick(); tick(); s_wr = 0;
    s_ready = 1;
    s_start = 1; tick(); s_start = 0;
    t0 = cyc;
    for (int c = 0; c < 4; c++) for (int b = 0; b < 2; b++) get_beat(c, b);
    chk("frame cycles", 64'(cyc - t0), 12);
    chk("frame done", s_done, 1);
    chk("frame busy", s_busy, 0);
    chk("frame addr wrap", 64'(s_addr), 0);
    chk("frame valid off", s_valid, 0);
    tick();
    chk("done one pulse", s_done, 0);
    chk("idle busy", s_busy, 0);
    // second frame: write-with-load keeps credit, start during SEND is ignored
    s_wr = 1; tick(); s_wr = 0;
    s_start = 1; tick(); s_start = 0;
    s_wr = 1; tick(); s_wr = 0;
    get_beat(0, 0);
    s_start = 1;
    get_beat(0, 1);
    s_start = 0;
    get_beat(1, 0);
    get_beat(1, 1);
    k = 0;
    for (int i = 0; i < 4; i++) begin
      k += s_valid;
      tick();
    end
    chk("credit exhausted", 64'(k), 0);
    chk("addr after cell1", 64'(s_addr), 2);
    s_wr = 1; tick(); tick(); s_wr = 0;
    for (int c = 2; c < 4; c++) for (int b = 0; b < 2; b++) get_beat(c, b);
    chk("frame2 done", s_done, 1);
    chk("frame2 addr", 64'(s_addr), 0);
    chk("frame2 busy", s_busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
